mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 32, memory data bus width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- req_valid, in, 1, core request valid.
- req_ready, out, 1, unit accepts request.
- req_we, in, 1, 1=store, 0=load.
- req_size, in, 2, 0=byte, 1=half, 2=word, 3=dword.
- req_unsigned, in, 1, zero-extend load.
- req_addr, in, ADDR_W, byte address.
- req_wdata, in, DATA_W, store data, LSB-aligned.
- rsp_valid, out, 1, response valid.
- rsp_ready, in, 1, core accepts response.
- rsp_rdata, out, DATA_W, extended load data; 0 for stores.
- rsp_err, out, 1, illegal size or unsupported misalignment.
- Address, out, ADDR_W, DATA_W/8-aligned memory address.
- MemWrite, out, 1, memory write request.
- MemRead, out, 1, memory read request.
- Write_data, out, DATA_W, lane-positioned store data.
- Write_strb, out, DATA_W/8, byte enables.
- Mem_Req_Ready, in, 1, memory accepts request.
- Read_data, in, DATA_W, memory read data.
- Read_data_Valid, in, 1, read data valid.
- Read_data_Ready, out, 1, unit accepts read data.
- ld_cnt, out, 32, completed loads.
- st_cnt, out, 32, completed stores.

Function
REQ-003 FSM states SHALL be IDLE, REQ1, RDW1, REQ2, RDW2, RSP.
REQ-004 Outputs per state:
- req_ready=1 only in IDLE.
- MemRead/MemWrite only in REQ1/REQ2.
- Read_data_Ready=1 only in RDW1/RDW2.
- rsp_valid=1 only in RSP.
REQ-005 IDLE with req_valid SHALL latch all req_* fields and go to REQ1; if the request is illegal, it SHALL go directly to RSP with rsp_err=1 and no memory traffic.
REQ-006 Illegality: req_size=3 with DATA_W=32; misaligned (addr not multiple of size) and MAU_MISALIGN_SPLIT_EN undefined.
REQ-007 REQ1/REQ2 SHALL hold request outputs stable until Mem_Req_Ready.
- Load: go to RDW1/RDW2.
- Store: go to REQ2 if split, else RSP.
REQ-008 RDW1/RDW2 SHALL capture Read_data on Read_data_Valid.
- RDW1: go to REQ2 if split, else RSP.
- RDW2: go to RSP.
REQ-009 RSP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready, then return to IDLE; back-to-back requests SHALL take one IDLE cycle between them.
REQ-010 Split: an access whose bytes cross a DATA_W/8 boundary SHALL issue two beats.
- Beat 1: Address=aligned(addr).
- Beat 2: Address=aligned(addr)+DATA_W/8.
- Each beat's Write_strb covers only its own bytes, little-endian.
REQ-011 Write_data SHALL place byte i of req_wdata on lane (addr+i) mod (DATA_W/8); unused lanes 0.
REQ-012 Load data SHALL be assembled little-endian from the beats, then sign- or zero-extended per req_unsigned from 8/16/32 bits; dword loads SHALL not be extended.
REQ-013 ld_cnt/st_cnt SHALL increment by 1 on the RSP handshake of a non-error load/store and SHALL wrap at 2^32.
REQ-014 A minimum load SHALL take 4 cycles from req handshake to rsp_valid with zero-wait memory (IDLE, REQ1, RDW1, RSP).

Reset
REQ-015 rst low SHALL asynchronously force:
- state IDLE.
- All outputs 0 except req_ready=1.
- Counters 0.
- Latched fields 0.
REQ-016 Reset mid-operation SHALL abandon the transaction with no response; the first post-reset cycle SHALL be IDLE.

Configuration
REQ-017 Macro MAU_MISALIGN_SPLIT_EN defined: misaligned accesses SHALL be split per REQ-010. Undefined: they SHALL return rsp_err=1 with no memory request, and states REQ2/RDW2 SHALL be unreachable.

Verification (DATA_W=32)
REQ-018 Byte load: lb at 0x103, memory 0x80AABBCC at 0x100 -> one read at 0x100, rsp_rdata=0xFFFFFF80; lbu gives 0x00000080.
REQ-019 Half store: sh at 0x102, wdata 0x1234 -> Address=0x100, Write_strb=1100, Write_data=0x12340000.
REQ-020 Split store with macro: sw at 0x103, wdata 0x11223344 -> beat 1 at 0x100 strb 1000 data 0x44000000; beat 2 at 0x104 strb 0111 data 0x00112233; st_cnt +1. Without macro -> rsp_err=1, MemWrite never high, st_cnt unchanged.
REQ-021 Split load: lw at 0x102, memory 0xAABBCCDD at 0x100 and 0x11223344 at 0x104 -> rsp_rdata=0x3344AABB.
REQ-022 Backpressure: Mem_Req_Ready low 3 cycles, then rsp_ready low 3 cycles -> MemRead/Address stable throughout; rsp_valid and rsp_rdata held; req_ready=0.
REQ-023 Reset in RDW1 -> next cycle all outputs at reset values, counters 0, no rsp_valid; the following request completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between a core request port and a DATA_W-wide memory port.
// Define MAU_MISALIGN_SPLIT_EN to split boundary-crossing accesses into two beats; otherwise misaligned accesses return rsp_err.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   Address,
    output logic                MemWrite,
    output logic                MemRead,
    output logic [DATA_W-1:0]   Write_data,
    output logic [DATA_W/8-1:0] Write_strb,
    input  logic                Mem_Req_Ready,
    input  logic [DATA_W-1:0]   Read_data,
    input  logic                Read_data_Valid,
    output logic                Read_data_Ready,
    output logic [31:0]         ld_cnt,
    output logic [31:0]         st_cnt
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

`ifdef MAU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REQ1, RDW1, REQ2, RDW2, RSP} state_e;

    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic crosses(input logic [1:0] size, input logic [OFF_W-1:0] off);
        return (int'(off) + size_bytes(size)) > NB;
    endfunction

    function automatic logic is_illegal(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic misaligned;
        misaligned = (int'(off) & (size_bytes(size) - 1)) != 0;
        return ((size == 2'd3) && (DATA_W == 32)) || (misaligned && !SPLIT_EN);
    endfunction

    function automatic logic [DATA_W-1:0] byte_mask(input logic [1:0] size);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < NB; i++) m[8*i +: 8] = (i < size_bytes(size)) ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Two beats are concatenated little-endian, shifted down by the byte offset, then extended.
    function automatic logic [DATA_W-1:0] load_extend(input logic [2*DATA_W-1:0] beats,
                                                      input logic [1:0] size, input logic uns,
                                                      input logic [OFF_W-1:0] off);
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] mask;
        logic              sign;
        val  = DATA_W'(beats >> {off, 3'b000});
        mask = byte_mask(size);
        case (size)
            2'd0:    sign = val[7];
            2'd1:    sign = val[15];
            2'd2:    sign = val[31];
            default: sign = 1'b0;
        endcase
        return (val & mask) | ({DATA_W{sign & ~uns}} & ~mask);
    endfunction

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                split_q, split_d;
    logic [DATA_W-1:0]   rd1_q, rd1_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [NB-1:0]       write_strb_q, write_strb_d;
    logic                rd_ready_q, rd_ready_d;
    logic [31:0]         ld_cnt_q, ld_cnt_d;
    logic [31:0]         st_cnt_q, st_cnt_d;

    logic [2*DATA_W-1:0] lane_data;
    logic [2*NB-1:0]     lane_strb;
    logic [NB-1:0]       strb_base;
    logic [ADDR_W-1:0]   beat_addr;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        split_d     = split_q;
        rd1_d       = rd1_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        ld_cnt_d    = ld_cnt_q;
        st_cnt_d    = st_cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d        = req_we;
                size_d      = req_size;
                uns_d       = req_unsigned;
                addr_d      = req_addr;
                wdata_d     = req_wdata;
                split_d     = crosses(req_size, req_addr[OFF_W-1:0]);
                rd1_d       = '0;
                rsp_rdata_d = '0;
                rsp_err_d   = is_illegal(req_size, req_addr[OFF_W-1:0]);
                state_d     = rsp_err_d ? RSP : REQ1;
            end
            REQ1: if (Mem_Req_Ready) state_d = !we_q ? RDW1 : (split_q ? REQ2 : RSP);
            RDW1: if (Read_data_Valid) begin
                rd1_d = Read_data;
                if (split_q) begin
                    state_d = REQ2;
                end else begin
                    state_d     = RSP;
                    rsp_rdata_d = load_extend({{DATA_W{1'b0}}, Read_data}, size_q, uns_q,
                                              addr_q[OFF_W-1:0]);
                end
            end
            REQ2: if (Mem_Req_Ready) state_d = we_q ? RSP : RDW2;
            RDW2: if (Read_data_Valid) begin
                state_d     = RSP;
                rsp_rdata_d = load_extend({Read_data, rd1_q}, size_q, uns_q, addr_q[OFF_W-1:0]);
            end
            RSP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                if (!rsp_err_q && we_q)  st_cnt_d = st_cnt_q + 32'd1;
                if (!rsp_err_q && !we_q) ld_cnt_d = ld_cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane placement is computed from the fields as they will be after this edge.
    always_comb begin
        for (int i = 0; i < NB; i++) strb_base[i] = (i < size_bytes(size_d));
        lane_data = {{DATA_W{1'b0}}, wdata_d & byte_mask(size_d)} << {addr_d[OFF_W-1:0], 3'b000};
        lane_strb = {{NB{1'b0}}, strb_base} << addr_d[OFF_W-1:0];
        beat_addr = {addr_d[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    always_comb begin
        req_ready_d  = (state_d == IDLE);
        mem_read_d   = ((state_d == REQ1) || (state_d == REQ2)) && !we_d;
        mem_write_d  = ((state_d == REQ1) || (state_d == REQ2)) && we_d;
        rd_ready_d   = (state_d == RDW1) || (state_d == RDW2);
        rsp_valid_d  = (state_d == RSP);
        address_d    = '0;
        write_data_d = '0;
        write_strb_d = '0;
        if (state_d == REQ1) begin
            address_d = beat_addr;
            if (we_d) begin
                write_data_d = lane_data[DATA_W-1:0];
                write_strb_d = lane_strb[NB-1:0];
            end
        end else if (state_d == REQ2) begin
            address_d = beat_addr + ADDR_W'(NB);
            if (we_d) begin
                write_data_d = lane_data[2*DATA_W-1:DATA_W];
                write_strb_d = lane_strb[2*NB-1:NB];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            split_q      <= 1'b0;
            rd1_q        <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            write_strb_q <= '0;
            rd_ready_q   <= 1'b0;
            ld_cnt_q     <= '0;
            st_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            split_q      <= split_d;
            rd1_q        <= rd1_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            req_ready_q  <= req_ready_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            write_strb_q <= write_strb_d;
            rd_ready_q   <= rd_ready_d;
            ld_cnt_q     <= ld_cnt_d;
            st_cnt_q     <= st_cnt_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign Address         = address_q;
    assign MemWrite        = mem_write_q;
    assign MemRead         = mem_read_q;
    assign Write_data      = write_data_q;
    assign Write_strb      = write_strb_q;
    assign Read_data_Ready = rd_ready_q;
    assign ld_cnt          = ld_cnt_q;
    assign st_cnt          = st_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32): scoreboard of expected responses and memory beats.
// Expectations for misaligned accesses follow whether MAU_MISALIGN_SPLIT_EN is defined.
module tb_mem_access_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = '0;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] Address;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] Write_data;
    logic [3:0]        Write_strb;
    logic              Mem_Req_Ready;
    logic [DATA_W-1:0] Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ready;
    logic [31:0]       ld_cnt;
    logic [31:0]       st_cnt;

    logic [31:0] mem [16];
    logic [31:0] rd_addr_l = '0;
    logic        mem_rdy_en = 1'b1;
    logic        rdv_en = 1'b1;
    beat_t       obs_q[$];
    rsp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_ld = 0;
    int          exp_st = 0;

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead), .Write_data(Write_data),
        .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
        .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
        .ld_cnt(ld_cnt), .st_cnt(st_cnt)
    );

    always #5 clk = ~clk;

    // Zero-wait memory unless throttled; read data comes from the last accepted read address.
    assign Mem_Req_Ready   = mem_rdy_en;
    assign Read_data_Valid = Read_data_Ready & rdv_en;
    assign Read_data       = mem[rd_addr_l[5:2]];

    always @(posedge clk) begin
        if (rst && (MemRead || MemWrite) && Mem_Req_Ready) begin
            obs_q.push_back({MemWrite, Address, Write_data, Write_strb});
            if (MemRead) rd_addr_l <= Address;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req_ready"}, req_ready, 1);
        check({tag, ".rsp_valid"}, rsp_valid, 0);
        check({tag, ".rsp_rdata"}, rsp_rdata, 0);
        check({tag, ".rsp_err"}, rsp_err, 0);
        check({tag, ".mem_rw"}, {MemRead, MemWrite}, 0);
        check({tag, ".address"}, Address, 0);
        check({tag, ".wdata_strb"}, {Write_data, Write_strb}, 0);
        check({tag, ".rd_ready"}, Read_data_Ready, 0);
        check({tag, ".counters"}, {ld_cnt, st_cnt}, 0);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int n_beats, input beat_t b1, input beat_t b2, input bit chk_lat);
        rsp_t exp;
        int   cyc;
        obs_q.delete();
        check({tag, ".req_ready"}, req_ready, 1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        rsp_ready    = 1'b1;
        exp_q.push_back({exp_rdata, exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!exp_err) begin
            if (we) exp_st++;
            else    exp_ld++;
        end
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".rsp_valid"}, rsp_valid, 1);
        if (!rsp_valid) begin
            exp_q.delete();
            return;
        end
        exp = exp_q.pop_front();
        check({tag, ".rsp_rdata"}, rsp_rdata, exp.rdata);
        check({tag, ".rsp_err"}, rsp_err, exp.err);
        if (chk_lat) check({tag, ".latency"}, cyc, 2);
        @(posedge clk); #1;
        check({tag, ".post_idle"}, {rsp_valid, req_ready}, 2'b01);
        check({tag, ".ld_cnt"}, ld_cnt, exp_ld);
        check({tag, ".st_cnt"}, st_cnt, exp_st);
        check({tag, ".n_beats"}, obs_q.size(), n_beats);
        for (int i = 0; i < n_beats && i < obs_q.size(); i++)
            check($sformatf("%s.beat%0d", tag, i), obs_q[i], (i == 0) ? b1 : b2);
    endtask

    initial begin
        beat_t none;
        none = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'h80AABBCC;

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        do_req("lb",  1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 1, '{1'b0, 32'h100, 32'h0, 4'h0}, none, 1'b1);
        do_req("lbu", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h00000080, 1'b0, 1, '{1'b0, 32'h100, 32'h0, 4'h0}, none, 1'b0);
        do_req("lh",  1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'hFFFF80AA, 1'b0, 1, '{1'b0, 32'h100, 32'h0, 4'h0}, none, 1'b0);
        do_req("lhu", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h000080AA, 1'b0, 1, '{1'b0, 32'h100, 32'h0, 4'h0}, none, 1'b0);
        do_req("lw",  1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h80AABBCC, 1'b0, 1, '{1'b0, 32'h100, 32'h0, 4'h0}, none, 1'b1);
        do_req("sh",  1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 32'h0, 1'b0, 1, '{1'b1, 32'h100, 32'h12340000, 4'b1100}, none, 1'b0);
        do_req("sb",  1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFFFFAB, 32'h0, 1'b0, 1, '{1'b1, 32'h100, 32'h0000AB00, 4'b0010}, none, 1'b0);

        mem[0] = 32'hAABBCCDD;
        mem[1] = 32'h11223344;
`ifdef MAU_MISALIGN_SPLIT_EN
        do_req("sw_split", 1'b1, 2'd2, 1'b0, 32'h103, 32'h11223344, 32'h0, 1'b0, 2,
               '{1'b1, 32'h100, 32'h44000000, 4'b1000}, '{1'b1, 32'h104, 32'h00112233, 4'b0111}, 1'b0);
        do_req("lw_split", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h3344AABB, 1'b0, 2,
               '{1'b0, 32'h100, 32'h0, 4'h0}, '{1'b0, 32'h104, 32'h0, 4'h0}, 1'b0);
        do_req("lh_mis", 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'hFFFFBBCC, 1'b0, 1,
               '{1'b0, 32'h100, 32'h0, 4'h0}, none, 1'b0);
`else
        do_req("sw_split", 1'b1, 2'd2, 1'b0, 32'h103, 32'h11223344, 32'h0, 1'b1, 0, none, none, 1'b0);
        do_req("lw_split", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 0, none, none, 1'b0);
        do_req("lh_mis", 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 0, none, none, 1'b0);
`endif
        do_req("dword", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 0, none, none, 1'b0);

        // Backpressure on both the memory request and the response.
        obs_q.delete();
        mem_rdy_en   = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h104;
        exp_q.push_back({32'h11223344, 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_req%0d", i), {MemRead, Address, req_ready}, {1'b1, 32'h104, 1'b0});
            @(posedge clk); #1;
        end
        mem_rdy_en = 1'b1;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        check("bp_rsp_valid", rsp_valid, 1);
        if (rsp_valid) begin
            rsp_t e;
            e = exp_q.pop_front();
            exp_ld++;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp_hold%0d", i), {rsp_valid, rsp_rdata, rsp_err, req_ready},
                      {1'b1, e.rdata, e.err, 1'b0});
                @(posedge clk); #1;
            end
        end else begin
            exp_q.delete();
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done", {rsp_valid, req_ready}, 2'b01);
        check("bp_ld_cnt", ld_cnt, exp_ld);
        check("bp_n_beats", obs_q.size(), 1);

        // Reset while waiting for read data abandons the load.
        rdv_en    = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !Read_data_Ready; i++) begin
            @(posedge clk); #1;
        end
        check("rst_in_rdw1", Read_data_Ready, 1);
        #2 rst = 1'b0;
        #1 check_idle("rst_async");
        @(posedge clk); #1;
        rst    = 1'b1;
        rdv_en = 1'b1;
        exp_ld = 0;
        exp_st = 0;
        check_idle("rst_release");
        @(posedge clk); #1;
        check("rst_no_rsp", rsp_valid, 0);
        do_req("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hAABBCCDD, 1'b0, 1,
               '{1'b0, 32'h100, 32'h0, 4'h0}, none, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
